// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
//   Registered ALU for the CPU execute stage. It combines two register-file
//   operands under a 4-bit opcode from the decoder. Arithmetic and logic
//   opcodes update the accumulator. Branch opcodes (11xx) instead drive
//   pc_branch, which the PC logic uses to select the branch target. Both
//   outputs are registered, so results appear one clock after the inputs
//   are sampled.
//
// Ports
//   clk        in   1      system clock, rising-edge active
//   rst_n      in   1      asynchronous active-low reset
//   alu_code   in   4      operation select
//   reg_data1  in   WIDTH  operand A
//   reg_data2  in   WIDTH  operand B
//   accum      out  WIDTH  registered result
//   pc_branch  out  1      registered branch-taken flag
//
// All arithmetic is unsigned and wraps modulo 2^WIDTH. No flags are produced.
// ---------------------------------------------------------------------------
module alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       alu_code,
  input  logic [WIDTH-1:0] reg_data1,
  input  logic [WIDTH-1:0] reg_data2,
  output logic [WIDTH-1:0] accum,
  output logic             pc_branch
);

  typedef enum logic [3:0] {
    OP_NOP = 4'b0000,
    OP_AND = 4'b0001,
    OP_OR  = 4'b0010,
    OP_XOR = 4'b0011,
    OP_SUB = 4'b0100,
    OP_NOT = 4'b0101,
    OP_SHL = 4'b0110,
    OP_SHR = 4'b0111,
    OP_ADD = 4'b1000,
    OP_INC = 4'b1001,
    OP_DEC = 4'b1010,
    OP_MOV = 4'b1011,
    OP_BEQ = 4'b1100,
    OP_BLT = 4'b1101,
    OP_BGT = 4'b1110,
    OP_BNE = 4'b1111
  } alu_op_e;

  alu_op_e          op;
  logic [3:0]       shamt;
  logic [WIDTH-1:0] next_accum;
  logic             next_branch;

  assign op    = alu_op_e'(alu_code);
  // Only the low nibble of B sets the shift distance. A shift by 16 therefore
  // behaves as a shift by 0, which matches the original datapath.
  assign shamt = reg_data2[3:0];

  // Next-state selection. The default is to hold the accumulator and clear
  // the branch flag. Only the opcodes listed below change either value.
  always_comb begin
    next_accum  = accum;
    next_branch = 1'b0;
    unique case (op)
      OP_NOP: next_accum = accum;
      OP_AND: next_accum = reg_data1 & reg_data2;
      OP_OR:  next_accum = reg_data1 | reg_data2;
      OP_XOR: next_accum = reg_data1 ^ reg_data2;
      OP_SUB: next_accum = reg_data1 - reg_data2;
      OP_NOT: next_accum = ~reg_data1;
      OP_SHL: next_accum = reg_data1 << shamt;
      OP_SHR: next_accum = reg_data1 >> shamt;
      OP_ADD: next_accum = reg_data1 + reg_data2;
      OP_INC: next_accum = reg_data1 + WIDTH'(1);
      OP_DEC: next_accum = reg_data1 - WIDTH'(1);
      OP_MOV: next_accum = reg_data2;
      // Branch compares leave the accumulator untouched. The flag reflects
      // only the most recent compare, so back-to-back branches overwrite it.
      OP_BEQ: next_branch = (reg_data1 == reg_data2);
      OP_BLT: next_branch = (reg_data1 <  reg_data2);
      OP_BGT: next_branch = (reg_data1 >  reg_data2);
      OP_BNE: next_branch = (reg_data1 != reg_data2);
      default: begin
        next_accum  = accum;
        next_branch = 1'b0;
      end
    endcase
  end

  // Output registers. Asserting reset clears both outputs at once and drops
  // any result still in flight. The first edge after reset is released
  // computes from the inputs present at that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accum     <= '0;
      pc_branch <= 1'b0;
    end else begin
      accum     <= next_accum;
      pc_branch <= next_branch;
    end
  end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu
//   Directed self-checking bench for alu. Inputs are driven on the falling
//   edge. Outputs are sampled 1 ns after the rising edge. Every expected value
//   is a hand-computed constant.
// ---------------------------------------------------------------------------
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [3:0]  alu_code;
  logic [15:0] reg_data1;
  logic [15:0] reg_data2;
  logic [15:0] accum;
  logic        pc_branch;

  int checks = 0;
  int errors = 0;

  alu #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_code  (alu_code),
    .reg_data1 (reg_data1),
    .reg_data2 (reg_data2),
    .accum     (accum),
    .pc_branch (pc_branch)
  );

  // Clock and reset initial values
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present one operation and let a single rising edge capture it
  task automatic step(input logic [3:0] code, input logic [15:0] a,
                      input logic [15:0] b);
    @(negedge clk);
    alu_code  = code;
    reg_data1 = a;
    reg_data2 = b;
    @(posedge clk);
    #1;
  endtask

  // Compare both outputs against the expected values
  task automatic check(input string tag, input logic [15:0] exp_accum,
                       input logic exp_branch);
    checks++;
    assert (accum === exp_accum) else begin
      errors++;
      $error("FAIL %s accum: observed %h expected %h", tag, accum, exp_accum);
    end
    checks++;
    assert (pc_branch === exp_branch) else begin
      errors++;
      $error("FAIL %s pc_branch: observed %b expected %b", tag, pc_branch,
             exp_branch);
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    alu_code  = 4'b1000;
    reg_data1 = 16'h1234;
    reg_data2 = 16'h4321;

    // Reset must act asynchronously, before any clock edge
    #2 rst_n = 1'b0;
    #1 check("reset_async", 16'h0000, 1'b0);
    // Reset must hold while low, even with a live ADD on the inputs
    repeat (3) @(posedge clk);
    #1 check("reset_held", 16'h0000, 1'b0);
    @(negedge clk);
    alu_code = 4'b0000;
    rst_n    = 1'b1;
    @(posedge clk);
    #1 check("nop_after_reset", 16'h0000, 1'b0);

    step(4'b1000, 16'h0001, 16'h003F); check("add", 16'h0040, 1'b0);
    step(4'b1000, 16'hFFFF, 16'h0001); check("add_wrap", 16'h0000, 1'b0);
    step(4'b0100, 16'h003F, 16'h0001); check("sub", 16'h003E, 1'b0);
    step(4'b0100, 16'h0000, 16'h0001); check("sub_wrap", 16'hFFFF, 1'b0);

    // Branches keep accum at FFFF
    step(4'b1100, 16'h0001, 16'h0001); check("beq_taken", 16'hFFFF, 1'b1);
    step(4'b1100, 16'h0001, 16'h0003); check("beq_not", 16'hFFFF, 1'b0);
    step(4'b1101, 16'h0001, 16'h0003); check("blt_taken", 16'hFFFF, 1'b1);
    step(4'b1101, 16'h0003, 16'h0001); check("blt_not", 16'hFFFF, 1'b0);
    step(4'b1110, 16'h0001, 16'h0003); check("bgt_not", 16'hFFFF, 1'b0);
    step(4'b1110, 16'h0003, 16'h0001); check("bgt_taken", 16'hFFFF, 1'b1);
    step(4'b1111, 16'h0005, 16'h0005); check("bne_not", 16'hFFFF, 1'b0);
    step(4'b1111, 16'h0005, 16'h0006); check("bne_taken", 16'hFFFF, 1'b1);
    // Unsigned compare: 8000 is larger than 0001
    step(4'b1101, 16'h8000, 16'h0001); check("blt_unsigned", 16'hFFFF, 1'b0);
    step(4'b1110, 16'h8000, 16'h0001); check("bgt_unsigned", 16'hFFFF, 1'b1);

    // A non-branch op must clear pc_branch
    step(4'b0001, 16'hF0F0, 16'h0FF0); check("and", 16'h00F0, 1'b0);
    step(4'b0010, 16'hF0F0, 16'h0FF0); check("or", 16'hFFF0, 1'b0);
    step(4'b0011, 16'hF0F0, 16'h0FF0); check("xor", 16'hFF00, 1'b0);
    step(4'b0101, 16'h00FF, 16'h1234); check("not", 16'hFF00, 1'b0);
    step(4'b0110, 16'h0001, 16'h0004); check("shl", 16'h0010, 1'b0);
    step(4'b0110, 16'h0001, 16'h0010); check("shl_by16", 16'h0001, 1'b0);
    step(4'b0111, 16'h8000, 16'h0013); check("shr", 16'h1000, 1'b0);
    step(4'b1001, 16'hFFFF, 16'h5555); check("inc_wrap", 16'h0000, 1'b0);
    step(4'b1010, 16'h0000, 16'h5555); check("dec_wrap", 16'hFFFF, 1'b0);
    step(4'b1011, 16'h1111, 16'hABCD); check("mov", 16'hABCD, 1'b0);
    step(4'b0000, 16'h1111, 16'h2222); check("nop_hold", 16'hABCD, 1'b0);
    step(4'b1100, 16'h0007, 16'h0007); check("beq_pulse", 16'hABCD, 1'b1);
    step(4'b0000, 16'h0007, 16'h0007); check("branch_one_cycle", 16'hABCD, 1'b0);

    // A reset asserted mid-cycle drops the pending ADD
    @(negedge clk);
    alu_code  = 4'b1000;
    reg_data1 = 16'h0001;
    reg_data2 = 16'h0001;
    #2 rst_n = 1'b0;
    #1 check("reset_midop", 16'h0000, 1'b0);
    @(posedge clk);
    #1 check("reset_midop_edge", 16'h0000, 1'b0);
    // Release reset. The first edge uses the inputs present at that edge
    @(negedge clk);
    rst_n     = 1'b1;
    reg_data1 = 16'h0002;
    reg_data2 = 16'h0003;
    @(posedge clk);
    #1 check("first_after_release", 16'h0005, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bounded run: guard against a stalled simulation
  initial begin
    #20000;
    $display("FAIL timeout: observed no completion, expected finish before 20000 ns");
    $fatal(1, "timeout");
  end

endmodule
